pipelined_adder_acc: RTL and testbench

- Parametrised successor to the team's 8-bit adder DUT: WIDTH-bit add/subtract/accumulate engine with a STAGES-deep elastic pipeline.
- Valid/ready handshake on both input and output sides, so drivers can apply back-to-back traffic and backpressure.
- Sits as a DUT behind the existing driver/monitor clocking-block bench style.
- The result carries an extra carry/borrow bit, as the current adder's 9-bit output does.

---
 rtl/pipelined_adder_acc.sv | 119 +++++++++++
 tb/tb_pipelined_adder_acc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_acc.sv
// pipelined_adder_acc: WIDTH-bit add / sub / accumulate / load engine behind
// a STAGES-deep elastic valid/ready pipeline. The result is WIDTH+1 bits,
// and its MSB is the carry (add/acc) or the borrow (sub).
// Optional build macro ADDER_SAT_EN clamps overflow and underflow instead of wrapping.
module pipelined_adder_acc #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out
);

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_ACC  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [STAGES-1:0] v_q, v_d, adv;
    logic [WIDTH:0]    d_q [STAGES];
    logic [WIDTH:0]    d_d [STAGES];
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH:0]    sum_add, diff_sub, sum_acc, res;
    logic              accept, go;

    assign sum_add  = {1'b0, in1} + {1'b0, in2};
    assign diff_sub = {1'b0, in1} - {1'b0, in2};
    assign sum_acc  = {1'b0, acc_q} + {1'b0, in1};

    // Advance chain, walked from the output back to stage 0. 'go' means the
    // next stage down the line can take a beat this cycle.
    always_comb begin
        adv = '0;
        go  = out_ready;
        for (int unsigned k = 0; k < STAGES; k++) begin
            adv[STAGES-1-k] = v_q[STAGES-1-k] && go;
            go              = !v_q[STAGES-1-k] || go;
        end
    end

    assign in_ready  = reset && (!v_q[0] || adv[0]);
    assign accept    = in_valid && in_ready;
    assign out_valid = v_q[STAGES-1];
    assign out       = d_q[STAGES-1];

    // Operation result and accumulator next state. The accumulator moves only on accept.
    always_comb begin
        res   = '0;
        acc_d = acc_q;
        case (mode_e'(mode))
            MODE_ADD: begin
                res = sum_add;
`ifdef ADDER_SAT_EN
                if (sum_add[WIDTH]) res[WIDTH-1:0] = '1;
`endif
            end
            MODE_SUB: begin
                res = diff_sub;
`ifdef ADDER_SAT_EN
                if (diff_sub[WIDTH]) res[WIDTH-1:0] = '0;
`endif
            end
            MODE_ACC: begin
                res = sum_acc;
`ifdef ADDER_SAT_EN
                if (sum_acc[WIDTH]) res[WIDTH-1:0] = '1;
`endif
                if (accept) acc_d = res[WIDTH-1:0];
            end
            default: begin
                res = {1'b0, in1};
                if (accept) acc_d = in1;
            end
        endcase
    end

    // Stage next state: a stage fills from its predecessor, or it empties when it advances.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (accept) begin
            v_d[0] = 1'b1;
            d_d[0] = res;
        end else if (adv[0]) begin
            v_d[0] = 1'b0;
        end
        for (int unsigned k = 1; k < STAGES; k++) begin
            if (adv[k-1]) begin
                v_d[k] = 1'b1;
                d_d[k] = d_q[k-1];
            end else if (adv[k]) begin
                v_d[k] = 1'b0;
            end
        end
    end

    // State registers. Reset discards any in-flight beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q   <= '0;
            acc_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) d_q[k] <= '0;
        end else begin
            v_q   <= v_d;
            acc_q <= acc_d;
            for (int unsigned k = 0; k < STAGES; k++) d_q[k] <= d_d[k];
        end
    end

endmodule

// File: tb/tb_pipelined_adder_acc.sv
// Testbench for pipelined_adder_acc. It runs directed scenarios plus randomized
// traffic, and a queue scoreboard is fed by an arithmetic reference model.
module tb_pipelined_adder_acc;

    localparam int W   = 8;
    localparam int STG = 2;

`ifdef ADDER_SAT_EN
    localparam logic [W:0] ADD0 = 9'h1FF;
    localparam logic [W:0] SUB0 = 9'h100;
    localparam logic [W:0] ACC2 = 9'h1FF;
    localparam logic [W:0] ACC3 = 9'h0FF;
`else
    localparam logic [W:0] ADD0 = 9'h12C;
    localparam logic [W:0] SUB0 = 9'h1FE;
    localparam logic [W:0] ACC2 = 9'h107;
    localparam logic [W:0] ACC3 = 9'h007;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in1, in2;
    logic [1:0]   mode;
    logic [W:0]   out;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_push = 0;
    int           n_pop = 0;
    longint       acc_m = 0;
    logic [W:0]   q[$];

    pipelined_adder_acc #(.WIDTH(W), .STAGES(STG)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic, computed with wide integers straight from the operation definitions.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] m);
        longint mx, r, low;
        logic   c;
        mx  = longint'(1) << W;
        c   = 1'b0;
        low = 0;
        case (m)
            2'd0: begin
                r = longint'(a) + longint'(b);
                c = (r >= mx);
                low = r % mx;
`ifdef ADDER_SAT_EN
                if (c) low = mx - 1;
`endif
            end
            2'd1: begin
                c = (a < b);
                low = (longint'(a) - longint'(b) + mx) % mx;
`ifdef ADDER_SAT_EN
                if (c) low = 0;
`endif
            end
            2'd2: begin
                r = acc_m + longint'(a);
                c = (r >= mx);
                low = r % mx;
`ifdef ADDER_SAT_EN
                if (c) low = mx - 1;
`endif
                acc_m = low;
            end
            default: begin
                acc_m = longint'(a);
                low = longint'(a);
            end
        endcase
        return {c, low[W-1:0]};
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] m);
        in_valid = v; in1 = a; in2 = b; mode = m;
    endtask

    // One clock cycle. The scoreboard is evaluated on the negedge, before the
    // edge that commits the handshake, and inputs are then free again #1 after the posedge.
    task automatic step();
        @(negedge clk);
        if (reset) begin
            if (q.size() == 0) check("ready_empty", in_ready, 1);
            if (q.size() == STG && !out_ready) check("ready_full", in_ready, 0);
            if (out_valid) begin
                if (q.size() == 0) check("spurious_valid", out_valid, 0);
                else check("out", out, q[0]);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                n_pop++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in1, in2, mode));
                n_push++;
            end
            if (q.size() > STG) check("occupancy", q.size(), STG);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, pp;
        reset = 1'b0; out_ready = 1'b0;
        drive(0, '0, '0, 2'd0);

        // Reset held for three cycles, then released.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_valid", out_valid, 0);
            check("rst_out", out, 0);
            check("rst_ready", in_ready, 0);
        end
        reset = 1'b1;
        #1;
        check("rel_ready", in_ready, 1);
        check("rel_valid", out_valid, 0);

        // Add streaming with out_ready held high.
        out_ready = 1'b1;
        drive(1, 8'd200, 8'd100, 2'd0); step();
        check("add_lat", out_valid, 0);
        drive(1, 8'd5, 8'd3, 2'd0); step();
        check("add0_v", out_valid, 1);
        check("add0", out, ADD0);
        drive(1, 8'd0, 8'd0, 2'd0); step();
        check("add1", out, 9'h008);
        drive(0, '0, '0, 2'd0); step();
        check("add2_v", out_valid, 1);
        check("add2", out, 9'h000);
        step();
        check("add_idle", out_valid, 0);

        // Subtraction with a borrow.
        drive(1, 8'd3, 8'd5, 2'd1); step();
        drive(0, '0, '0, 2'd0); step();
        check("sub_v", out_valid, 1);
        check("sub", out, SUB0);
        step();

        // Accumulate chain. The final acc-of-zero beat reads back the accumulator.
        drive(1, 8'd250, 8'd0, 2'd3); step();
        drive(1, 8'd3, 8'd0, 2'd2); step();
        check("acc0", out, 9'h0FA);
        drive(1, 8'd10, 8'd0, 2'd2); step();
        check("acc1", out, 9'h0FD);
        drive(1, 8'd0, 8'd0, 2'd2); step();
        check("acc2", out, ACC2);
        drive(0, '0, '0, 2'd0); step();
        check("acc_read", out, ACC3);
        step();

        // Backpressure: three beats are offered while the output is stalled.
        out_ready = 1'b0;
        p0 = n_push;
        drive(1, 8'd1, 8'd1, 2'd0); step();
        drive(1, 8'd2, 8'd2, 2'd0); step();
        drive(1, 8'd3, 8'd3, 2'd0); step();
        check("bp_ready", in_ready, 0);
        check("bp_accepted", n_push - p0, 2);
        step(); step();
        check("bp_hold_v", out_valid, 1);
        check("bp_hold", out, 9'h002);
        check("bp_still2", n_push - p0, 2);
        out_ready = 1'b1;
        pp = n_pop;
        for (int i = 0; i < 3; i++) begin
            step();
            if (n_push - p0 == 3) in_valid = 1'b0;
        end
        check("bp_emit", n_pop - pp, 3);
        check("bp_empty", q.size(), 0);
        drive(0, '0, '0, 2'd0);

        // Reset while two beats are in flight.
        out_ready = 1'b0;
        drive(1, 8'd9, 8'd9, 2'd0); step();
        drive(1, 8'd4, 8'd4, 2'd0); step();
        drive(0, '0, '0, 2'd0);
        reset = 1'b0;
        q.delete();
        acc_m = 0;
        #1;
        check("mid_rst_v", out_valid, 0);
        check("mid_rst_rdy", in_ready, 0);
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_pulse", out_valid, 0);
        end
        drive(1, 8'd7, 8'd0, 2'd2); step();
        drive(0, '0, '0, 2'd0); step();
        check("post_rst_acc", out, 9'h007);
        step();

        // Randomized traffic and backpressure.
        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 7) == 0) a = '1;
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 7) == 0) b = '1;
            drive($urandom_range(0, 9) < 7, a, b, 2'($urandom_range(0, 3)));
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        // Drain.
        drive(0, '0, '0, 2'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 2 * STG + 4; i++) step();
        check("drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
